cs_countdown: RTL
=================

# cs_countdown

Loadable 4-digit BCD countdown timer (SS.cc, 00.00–99.99 s) with start/stop/pause control and an expiry pulse. It is the down-counting counterpart of the team's centisecond up-counter and shares its prescaled 10 ms tick. Its BCD `count` output drives the same seven-segment display path. Typical use: lab stopwatch and countdown modes on the board.

## Interface
- `TICK_DIV`, default 1_000_000: clock cycles per count decrement (10 ms at 100 MHz); must be ≥ 2.
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load` in 1: load preset from `load_val`; sampled each cycle.
- `load_val` in 16: BCD preset, 4 nibbles `[15:12]` = tens of seconds down to `[3:0]` = hundredths.
- `start` in 1: begin or resume counting.
- `stop` in 1: pause counting.
- `count` out 16: current BCD value, same nibble layout as `load_val`.
- `running` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on expiry.
- `expired` out 1: high while in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Internal registers: 20-bit prescaler `pre`, 16-bit `preset`.
- Reset values: `count`=0x0000, `preset`=0x0000, `pre`=0, state IDLE, `running`=0, `done`=0, `expired`=0.
- Input priority: `rst` > `load` > `stop` > `start`.
- `load`, any state: the sanitized `load_val` goes to both `count` and `preset`. `pre` clears to 0. State goes to IDLE.
- Sanitizing: any nibble > 9 is clamped to 9, e.g. 0x1A3F → 0x1939.
- IDLE + `start` with `count` ≠ 0 → RUN, `pre`=0. If `count`=0, `start` is ignored.
- RUN: `pre` increments each cycle. When `pre`==TICK_DIV-1, `pre` wraps to 0 and `count` decrements by one hundredth.
- BCD decrement: a digit at 0 becomes 9 and borrows from the next digit up (e.g. 10.00 → 09.99).
- RUN + `stop` → PAUSE. `pre` and `count` are held. A `stop` in the same cycle as a tick wins: no decrement.
- PAUSE + `start` → RUN, resuming from the held `pre` value.
- PAUSE + `stop` → stays in PAUSE.
- Expiry: a tick while `count`==0x0001 → `count`=0x0000, state DONE, `done`=1 for exactly one cycle.
- DONE: `expired`=1. `start` and `stop` are ignored. Only `load` or `rst` leaves DONE.
- `start` while in RUN: no effect.
- `running`, `expired` and `done` are registered outputs; no combinational path from inputs to outputs.

## Timing
- All outputs are registered; every effect is visible one cycle after the triggering edge.
- `load` at edge N → `count`=preset at N+1.
- `start` at edge N → `running`=1 at N+1. First decrement at edge N+TICK_DIV; `count` shows it at N+TICK_DIV+1.
- Period between decrements in RUN: exactly TICK_DIV cycles.
- `done` is high in the same cycle that `count` first reads 0x0000. `expired` rises in that same cycle.
- `rst` mid-RUN: next cycle all outputs return to reset values; `preset` is lost.

## Configuration
- Macro: `CS_COUNTDOWN_AUTORELOAD_EN`.
- Defined:
  - On expiry, `count` reloads `preset` in the same edge, not 0x0000.
  - `done` pulses for one cycle and the state stays RUN.
  - `expired` is never asserted.
  - `pre` continues from 0, so the period is exactly (preset×TICK_DIV) cycles.
- Undefined: expiry behaviour is as described under Operation.

## Test plan
Run all scenarios with TICK_DIV=4.
- Reset then idle 20 cycles → `count`=0x0000, `running`=0, `done`=0, `expired`=0; `start` ignored.
- `load` 0x0003, `start` at cycle 0 → `count` shows 0x0002, 0x0001, 0x0000 at cycles 5, 9, 13. `done`=1 only at cycle 13. `expired`=1 from cycle 13.
- `load` 0x1000, run one tick → `count`=0x0999. `load` 0xFFFF → `count`=0x9999.
- In RUN, assert `stop` coincident with a tick edge → no decrement; `count` is held for 10 cycles. `start` → next decrement after the remaining prescale cycles, with no full-period restart.
- `load` and `stop` asserted together in RUN → IDLE with the new value. `rst` mid-RUN → reset values next cycle.
- With the macro defined: `load` 0x0002 and run 20 cycles → `done` pulses every 8 cycles, `count` sequence 2,1,2,1…, `expired`=0.

Source files
------------

// File: rtl/cs_countdown.sv
// cs_countdown -- loadable 4-digit BCD countdown timer (SS.cc, 00.00-99.99 s).
//
// Counts down one hundredth every TICK_DIV clock cycles while running, with
// start/stop/pause control, a one-cycle expiry pulse and an expired flag.
//
// Optional feature macro: CS_COUNTDOWN_AUTORELOAD_EN
//   When defined, expiry reloads the preset and keeps running (periodic
//   timer); `expired` is never asserted.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   load      in   load sanitized load_val into count and preset, go IDLE
//   load_val  in   16-bit BCD preset, [15:12] tens of s .. [3:0] hundredths
//   start     in   begin / resume counting
//   stop      in   pause counting
//   count     out  current BCD value
//   running   out  high while in RUN
//   done      out  one-cycle pulse on expiry
//   expired   out  high while in DONE
module cs_countdown #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        expired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [19:0] PRE_LAST = 20'(TICK_DIV - 1);

  state_t      state, state_d;
  logic [19:0] pre, pre_d;
  logic [15:0] preset, preset_d;
  logic [15:0] count_d;
  logic        done_d;

  // Clamp each nibble to a legal BCD digit.
  function automatic logic [15:0] bcd_sanitize(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Subtract one hundredth; a zero digit wraps to 9 and borrows upward.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state;
    pre_d    = pre;
    preset_d = preset;
    count_d  = count;
    done_d   = 1'b0;
    if (load) begin
      count_d  = bcd_sanitize(load_val);
      preset_d = bcd_sanitize(load_val);
      pre_d    = 20'd0;
      state_d  = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // stop outranks start, so a simultaneous stop blocks the start.
          if (!stop && start && count != 16'h0000) begin
            state_d = RUN;
            pre_d   = 20'd0;
          end
        end
        RUN: begin
          if (stop) begin
            // Stop wins over a coincident tick: pre and count are held.
            state_d = PAUSE;
          end else if (pre == PRE_LAST) begin
            pre_d = 20'd0;
            if (count == 16'h0001) begin
              done_d = 1'b1;
`ifdef CS_COUNTDOWN_AUTORELOAD_EN
              count_d = preset;
`else
              count_d = 16'h0000;
              state_d = DONE;
`endif
            end else begin
              count_d = bcd_dec(count);
            end
          end else begin
            pre_d = pre + 20'd1;
          end
        end
        PAUSE: begin
          // Resume keeps the partially elapsed prescale count.
          if (!stop && start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pre    <= 20'd0;
      preset <= 16'h0000;
      count  <= 16'h0000;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      pre    <= pre_d;
      preset <= preset_d;
      count  <= count_d;
      done   <= done_d;
    end
  end

  // Decodes of the state register only; no input reaches these directly.
  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule
